// File: rtl/gate_bist_seq.sv
// BIST sequencer: applies every gate input pattern, holds it SETTLE+1 cycles, then compares Z to EXPECT (CARE-masked).
// Full run is 2^N_IN*(SETTLE+2)+1 cycles from START to DONE; BIST_CONTINUE_EN keeps running past mismatches and adds ERR_CNT.
module gate_bist_seq #(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 10,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1000,
  parameter logic [(1<<N_IN)-1:0]  CARE   = 4'b1111
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            Z,
  output logic [N_IN-1:0] DRV,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN-1:0] FAIL_IDX,
  output logic            FAIL_VAL
`ifdef BIST_CONTINUE_EN
  ,
  output logic [N_IN:0]   ERR_CNT
`endif
);

  localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [N_IN:0]  IDX_LAST = (N_IN + 1)'((1 << N_IN) - 1);
  localparam logic [N_IN:0]  IDX_ONE  = (N_IN + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] drv_q, drv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;
  logic            fail_val_q, fail_val_d;
  logic            mismatch;
`ifdef BIST_CONTINUE_EN
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
`endif

  // Don't-care patterns are still driven but can never flag a mismatch.
  assign mismatch = CARE[idx_q[N_IN-1:0]] && (Z != EXPECT[idx_q[N_IN-1:0]]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    drv_d      = drv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    fail_val_d = fail_val_q;
`ifdef BIST_CONTINUE_EN
    err_cnt_d  = err_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_APPLY;
          idx_d      = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          fail_val_d = 1'b0;
`ifdef BIST_CONTINUE_EN
          err_cnt_d  = '0;
`endif
        end
      end

      S_APPLY: begin
        drv_d   = idx_q[N_IN-1:0];
        cnt_d   = CNT_INIT;
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_CHECK: begin
`ifdef BIST_CONTINUE_EN
        if (mismatch) begin
          err_cnt_d = err_cnt_q + IDX_ONE;
          if (err_cnt_q == '0) begin
            fail_idx_d = idx_q[N_IN-1:0];
            fail_val_d = Z;
          end
        end
        if (idx_q == IDX_LAST) begin
          pass_d  = (err_cnt_d == '0);
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_APPLY;
        end
`else
        if (mismatch) begin
          fail_idx_d = idx_q[N_IN-1:0];
          fail_val_d = Z;
          pass_d     = 1'b0;
          state_d    = S_FINISH;
        end else if (idx_q == IDX_LAST) begin
          pass_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_APPLY;
        end
`endif
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      drv_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      fail_val_q <= 1'b0;
`ifdef BIST_CONTINUE_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      drv_q      <= drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      fail_val_q <= fail_val_d;
`ifdef BIST_CONTINUE_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign DRV      = drv_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign FAIL_IDX = fail_idx_q;
  assign FAIL_VAL = fail_val_q;
`ifdef BIST_CONTINUE_EN
  assign ERR_CNT  = err_cnt_q;
`endif

endmodule

// File: tb/tb_gate_bist_seq.sv
// Bench for gate_bist_seq: a shared emulated gate (truth table tt) drives two sequencers, one fully checked, one with CARE=4'b1011.
module tb_gate_bist_seq;

  localparam int         N_IN   = 2;
  localparam int         SETTLE = 10;
  localparam int         NP     = 1 << N_IN;
  localparam int         PER    = SETTLE + 2;
  localparam logic [3:0] EXP    = 4'b1000;
  localparam logic [3:0] CARE0  = 4'b1111;
  localparam logic [3:0] CARE1  = 4'b1011;

  logic            CLK = 1'b0;
  logic            RST;
  logic            START;
  logic [3:0]      tt;
  logic            z0, z1;
  logic [N_IN-1:0] drv0, drv1, fidx0, fidx1;
  logic            busy0, busy1, done0, done1, pass0, pass1, fval0, fval1;
`ifdef BIST_CONTINUE_EN
  logic [N_IN:0]   ecnt0, ecnt1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  assign z0 = tt[drv0];
  assign z1 = tt[drv1];

  gate_bist_seq #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECT(EXP), .CARE(CARE0)) dut0 (
    .CLK(CLK), .RST(RST), .START(START), .Z(z0), .DRV(drv0), .BUSY(busy0),
    .DONE(done0), .PASS(pass0), .FAIL_IDX(fidx0), .FAIL_VAL(fval0)
`ifdef BIST_CONTINUE_EN
    , .ERR_CNT(ecnt0)
`endif
  );

  gate_bist_seq #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECT(EXP), .CARE(CARE1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .Z(z1), .DRV(drv1), .BUSY(busy1),
    .DONE(done1), .PASS(pass1), .FAIL_IDX(fidx1), .FAIL_VAL(fval1)
`ifdef BIST_CONTINUE_EN
    , .ERR_CNT(ecnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: walk the truth table with plain arithmetic; run length follows from where the walk stops.
  task automatic model(input logic [3:0] gate_tt, input logic [3:0] care,
                       output logic pass, output int fidx, output logic fval,
                       output int errs, output int done_cyc);
    int stop;
    errs = 0; fidx = 0; fval = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (care[k] && (gate_tt[k] != EXP[k])) begin
        if (errs == 0) begin
          fidx = k;
          fval = gate_tt[k];
        end
        errs++;
      end
    end
    pass = (errs == 0);
`ifdef BIST_CONTINUE_EN
    stop = NP - 1;
`else
    stop = (errs == 0) ? NP - 1 : fidx;
`endif
    done_cyc = (stop + 1) * PER + 1;
  endtask

  task automatic run(input logic [3:0] gate_tt, input bit repulse);
    logic p0, p1, fv0, fv1;
    int   fi0, fi1, er0, er1, dc0, dc1;
    int   d0, d1;
    model(gate_tt, CARE0, p0, fi0, fv0, er0, dc0);
    model(gate_tt, CARE1, p1, fi1, fv1, er1, dc1);
    tt = gate_tt;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    check("busy_after_start", {31'b0, busy0}, 1);
    d0 = -1; d1 = -1;
    for (int e = 1; e <= 200 && (d0 < 0 || d1 < 0); e++) begin
      @(negedge CLK);
      START = (repulse && (e == 5 || e == 30)) ? 1'b1 : 1'b0;
      if (e < dc0)
        check("drv_pattern", {30'b0, drv0}, (e - 1) / PER);
      if (done0 && d0 < 0) begin
        d0 = e;
        check("pass0", {31'b0, pass0}, {31'b0, p0});
        check("fail_idx0", {30'b0, fidx0}, fi0);
        check("fail_val0", {31'b0, fval0}, {31'b0, fv0});
        check("busy_at_done", {31'b0, busy0}, 0);
`ifdef BIST_CONTINUE_EN
        check("err_cnt0", {29'b0, ecnt0}, er0);
`endif
      end
      if (done1 && d1 < 0) begin
        d1 = e;
        check("pass1", {31'b0, pass1}, {31'b0, p1});
        check("fail_idx1", {30'b0, fidx1}, fi1);
        check("fail_val1", {31'b0, fval1}, {31'b0, fv1});
`ifdef BIST_CONTINUE_EN
        check("err_cnt1", {29'b0, ecnt1}, er1);
`endif
      end
    end
    START = 1'b0;
    check("done_latency0", d0, dc0);
    check("done_latency1", d1, dc1);
    @(negedge CLK);
    check("done_one_cycle", {30'b0, done0, done1}, 0);
    check("pass_held", {31'b0, pass0}, {31'b0, p0});
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int ndone;
    RST = 1'b1; START = 1'b0; tt = 4'b1000;
    repeat (3) @(negedge CLK);
    check("rst_drv", {30'b0, drv0}, 0);
    check("rst_flags", {28'b0, busy0, done0, pass0, fval0}, 0);
    check("rst_fail_idx", {30'b0, fidx0}, 0);
    RST = 1'b0;
    @(negedge CLK);

    run(4'b1000, 1'b0);   // correct AND
    run(4'b0000, 1'b0);   // Z stuck-at-0
    run(4'b1110, 1'b0);   // OR in place of AND
    run(4'b1100, 1'b0);   // wrong only on pattern 2
    run(4'b1000, 1'b1);   // START re-pulsed mid-run

    // Reset 20 cycles into a run aborts without DONE.
    tt = 4'b1000;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (20) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_busy", {31'b0, busy0}, 0);
    check("abort_drv", {30'b0, drv0}, 0);
    check("abort_done", {31'b0, done0}, 0);
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (done0 || busy0) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // START coincident with RST is dropped.
    @(negedge CLK); RST = 1'b1; START = 1'b1;
    @(negedge CLK); RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    check("rst_beats_start", {31'b0, busy0}, 0);

    run(4'b1000, 1'b0);
    for (int r = 0; r < 6; r++)
      run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
